// File: rtl/sdram_bist_pkg.sv
// Shared types and constants for the SDRAM built-in self test.
package sdram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_FILL  = 3'd1,
        ST_WR_CMD   = 3'd2,
        ST_RD_CMD   = 3'd3,
        ST_RD_DRAIN = 3'd4,
        ST_DONE     = 3'd5
    } bist_state_t;

    typedef enum logic [1:0] {
        PM_ALT   = 2'd0,
        PM_ADDR  = 2'd1,
        PM_WALK1 = 2'd2,
        PM_LFSR  = 2'd3
    } pat_mode_t;

    localparam logic [15:0] ALT_EVEN  = 16'hAAAA;
    localparam logic [15:0] ALT_ODD   = 16'h5555;
    // Fibonacci taps for x^16+x^14+x^13+x^11+1 on a right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/sdram_bist_patgen.sv
// Test pattern generator: one word per advance, restarted by load so the read
// phase regenerates exactly the sequence written.
module sdram_bist_patgen
    import sdram_bist_pkg::*;
#(
    parameter int          DATA_W = 16,
    parameter int          ADR_W  = 25,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              adv,
    input  logic [1:0]        mode,
    input  logic [ADR_W-1:0]  adr,
    output logic [DATA_W-1:0] pat
);

    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [DATA_W-1:0] WALK_INIT = {{(DATA_W-1){1'b0}}, 1'b1};

    logic              odd_r;
    logic [DATA_W-1:0] walk_r;
    logic [15:0]       lfsr_r;

    function automatic logic [DATA_W-1:0] rep16(input logic [15:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[i[3:0]];
        end
        return r;
    endfunction

    // Index-dependent state; the walking one rotates instead of computing k mod DATA_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odd_r  <= 1'b0;
            walk_r <= WALK_INIT;
            lfsr_r <= SEED_NZ;
        end else if (load) begin
            odd_r  <= 1'b0;
            walk_r <= WALK_INIT;
            lfsr_r <= SEED_NZ;
        end else if (adv) begin
            odd_r  <= ~odd_r;
            walk_r <= {walk_r[DATA_W-2:0], walk_r[DATA_W-1]};
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    // Pattern word selection
    always_comb begin
        pat = {DATA_W{1'b0}};
        case (mode)
            PM_ALT:   pat = odd_r ? rep16(ALT_ODD) : rep16(ALT_EVEN);
            PM_ADDR:  pat = DATA_W'(adr);
            PM_WALK1: pat = walk_r;
            PM_LFSR:  pat = rep16(lfsr_r);
            default:  pat = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/sdram_bist.sv
// SDRAM BIST: writes NUM_BURSTS bursts of a selected pattern through the
// controller user port, reads them back and counts mismatching words.
module sdram_bist
    import sdram_bist_pkg::*;
#(
    parameter int               DATA_W     = 16,
    parameter int               ADR_W      = 25,
    parameter int               LEN_W      = 10,
    parameter int               BURST_LEN  = 8,
    parameter int               NUM_BURSTS = 16,
    parameter logic [ADR_W-1:0] BASE_ADR   = {ADR_W{1'b0}},
    parameter logic [15:0]      SEED       = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_fin,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADR_W-1:0]  first_err_adr,
    output logic              cmd_en,
    output logic              cmd_wr_rd,
    input  logic              cmd_av,
    output logic [LEN_W-1:0]  cmd_len,
    output logic [ADR_W-1:0]  cmd_adr,
    input  logic [LEN_W-1:0]  wr_remain_space,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rd_av,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data
);

    localparam int               BW         = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [BW-1:0]    LAST_BURST = BW'(NUM_BURSTS - 1);
    localparam logic [BW-1:0]    BURST_ONE  = BW'(1);
    localparam logic [LEN_W-1:0] BLEN       = LEN_W'(BURST_LEN);
    localparam logic [LEN_W-1:0] BLEN_M1    = LEN_W'(BURST_LEN - 1);
    localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);
    localparam logic [ADR_W-1:0] ADR_STEP   = ADR_W'(BURST_LEN);
    localparam logic [ADR_W-1:0] ADR_ONE    = ADR_W'(1);

    bist_state_t       state_r;
    logic [1:0]        mode_r;
    logic [BW-1:0]     burst_r;
    logic [ADR_W-1:0]  burst_adr_r;
    logic [ADR_W-1:0]  word_adr_r;
    logic [LEN_W-1:0]  word_cnt_r;
    logic [LEN_W-1:0]  pop_cnt_r;
    logic              filling_r;
    logic              rd_arm_r;
    logic              rd_valid_r;
    logic              busy_r, done_r, pass_r;
    logic [15:0]       err_cnt_r;
    logic [ADR_W-1:0]  first_err_r;
    logic              cmd_en_r, cmd_wr_rd_r;
    logic [LEN_W-1:0]  cmd_len_r;
    logic [ADR_W-1:0]  cmd_adr_r;
    logic              wr_en_r;
    logic [DATA_W-1:0] wr_data_r;

    logic              start_ok_s, fill_go_s, gen_load_s, gen_adv_s;
    logic              pop_s, mismatch_s, abort_s;
    logic [DATA_W-1:0] pat_s;

    // Handshake decodes shared by the FSM and the pattern generator
    always_comb begin
        start_ok_s = start && init_fin && (state_r == ST_IDLE || state_r == ST_DONE);
        fill_go_s  = (state_r == ST_WR_FILL) && (filling_r || (wr_remain_space >= BLEN));
        gen_load_s = start_ok_s ||
                     ((state_r == ST_WR_CMD) && cmd_av && (burst_r == LAST_BURST));
        gen_adv_s  = fill_go_s || ((state_r == ST_RD_DRAIN) && rd_valid_r);
        pop_s      = rd_arm_r && rd_av;
        mismatch_s = (state_r == ST_RD_DRAIN) && rd_valid_r && (rd_data != pat_s);
        abort_s    = busy_r && !init_fin;
    end

    sdram_bist_patgen #(
        .DATA_W (DATA_W),
        .ADR_W  (ADR_W),
        .SEED   (SEED)
    ) u_patgen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (gen_load_s),
        .adv   (gen_adv_s),
        .mode  (mode_r),
        .adr   (word_adr_r),
        .pat   (pat_s)
    );

    // Test sequencer with registered status and strobe outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            mode_r      <= 2'd0;
            burst_r     <= {BW{1'b0}};
            burst_adr_r <= {ADR_W{1'b0}};
            word_adr_r  <= {ADR_W{1'b0}};
            word_cnt_r  <= {LEN_W{1'b0}};
            pop_cnt_r   <= {LEN_W{1'b0}};
            filling_r   <= 1'b0;
            rd_arm_r    <= 1'b0;
            rd_valid_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_cnt_r   <= 16'h0000;
            first_err_r <= {ADR_W{1'b0}};
            cmd_en_r    <= 1'b0;
            cmd_wr_rd_r <= 1'b0;
            cmd_len_r   <= {LEN_W{1'b0}};
            cmd_adr_r   <= {ADR_W{1'b0}};
            wr_en_r     <= 1'b0;
            wr_data_r   <= {DATA_W{1'b0}};
        end else begin
            cmd_en_r <= 1'b0;
            wr_en_r  <= 1'b0;
            if (abort_s) begin
                // Controller lost initialisation: report failure, keep error count
                state_r    <= ST_DONE;
                busy_r     <= 1'b0;
                done_r     <= 1'b1;
                pass_r     <= 1'b0;
                filling_r  <= 1'b0;
                rd_arm_r   <= 1'b0;
                rd_valid_r <= 1'b0;
            end else begin
                rd_valid_r <= pop_s;
                case (state_r)
                    ST_IDLE, ST_DONE: begin
                        if (start_ok_s) begin
                            state_r     <= ST_WR_FILL;
                            mode_r      <= mode;
                            busy_r      <= 1'b1;
                            done_r      <= 1'b0;
                            pass_r      <= 1'b0;
                            err_cnt_r   <= 16'h0000;
                            first_err_r <= {ADR_W{1'b0}};
                            burst_r     <= {BW{1'b0}};
                            burst_adr_r <= BASE_ADR;
                            word_adr_r  <= BASE_ADR;
                            word_cnt_r  <= {LEN_W{1'b0}};
                        end
                    end
                    ST_WR_FILL: begin
                        if (fill_go_s) begin
                            wr_en_r    <= 1'b1;
                            wr_data_r  <= pat_s;
                            word_adr_r <= word_adr_r + ADR_ONE;
                            if (word_cnt_r == BLEN_M1) begin
                                word_cnt_r <= {LEN_W{1'b0}};
                                filling_r  <= 1'b0;
                                state_r    <= ST_WR_CMD;
                            end else begin
                                word_cnt_r <= word_cnt_r + LEN_ONE;
                                filling_r  <= 1'b1;
                            end
                        end
                    end
                    ST_WR_CMD: begin
                        if (cmd_av) begin
                            cmd_en_r    <= 1'b1;
                            cmd_wr_rd_r <= 1'b0;
                            cmd_len_r   <= BLEN;
                            cmd_adr_r   <= burst_adr_r;
                            if (burst_r == LAST_BURST) begin
                                burst_r     <= {BW{1'b0}};
                                burst_adr_r <= BASE_ADR;
                                word_adr_r  <= BASE_ADR;
                                state_r     <= ST_RD_CMD;
                            end else begin
                                burst_r     <= burst_r + BURST_ONE;
                                burst_adr_r <= burst_adr_r + ADR_STEP;
                                state_r     <= ST_WR_FILL;
                            end
                        end
                    end
                    ST_RD_CMD: begin
                        if (cmd_av) begin
                            cmd_en_r    <= 1'b1;
                            cmd_wr_rd_r <= 1'b1;
                            cmd_len_r   <= BLEN;
                            cmd_adr_r   <= burst_adr_r;
                            burst_adr_r <= burst_adr_r + ADR_STEP;
                            pop_cnt_r   <= {LEN_W{1'b0}};
                            word_cnt_r  <= {LEN_W{1'b0}};
                            rd_arm_r    <= 1'b1;
                            state_r     <= ST_RD_DRAIN;
                        end
                    end
                    ST_RD_DRAIN: begin
                        if (pop_s) begin
                            pop_cnt_r <= pop_cnt_r + LEN_ONE;
                            if (pop_cnt_r == BLEN_M1) begin
                                rd_arm_r <= 1'b0;
                            end else begin
                                rd_arm_r <= 1'b1;
                            end
                        end
                        if (rd_valid_r) begin
                            word_adr_r <= word_adr_r + ADR_ONE;
                            if (mismatch_s) begin
                                if (err_cnt_r != 16'hFFFF) begin
                                    err_cnt_r <= err_cnt_r + 16'h0001;
                                end
                                if (err_cnt_r == 16'h0000) begin
                                    first_err_r <= word_adr_r;
                                end
                            end
                            if (word_cnt_r == BLEN_M1) begin
                                word_cnt_r <= {LEN_W{1'b0}};
                                if (burst_r == LAST_BURST) begin
                                    state_r <= ST_DONE;
                                    busy_r  <= 1'b0;
                                    done_r  <= 1'b1;
                                    pass_r  <= (err_cnt_r == 16'h0000) && !mismatch_s;
                                end else begin
                                    burst_r <= burst_r + BURST_ONE;
                                    state_r <= ST_RD_CMD;
                                end
                            end else begin
                                word_cnt_r <= word_cnt_r + LEN_ONE;
                            end
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_cnt       = err_cnt_r;
    assign first_err_adr = first_err_r;
    assign cmd_en        = cmd_en_r;
    assign cmd_wr_rd     = cmd_wr_rd_r;
    assign cmd_len       = cmd_len_r;
    assign cmd_adr       = cmd_adr_r;
    assign wr_en         = wr_en_r;
    assign wr_data       = wr_data_r;
    // Gated by rd_av so the read FIFO is never popped while empty
    assign rd_en         = rd_arm_r && rd_av;

endmodule

// File: tb/tb_sdram_bist.sv
// Scoreboard bench for sdram_bist with a behavioural SDRAM controller model.
module tb_sdram_bist;

    localparam int BL = 3;
    localparam int NB = 2;
    localparam int NW = BL * NB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_fin = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    logic [24:0] first_err_adr;
    logic        cmd_en, cmd_wr_rd;
    logic        cmd_av = 1'b0;
    logic [9:0]  cmd_len;
    logic [24:0] cmd_adr;
    logic [9:0]  wr_remain_space = 10'd0;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_av = 1'b0;
    logic        rd_en;
    logic [15:0] rd_data = 16'h0000;

    sdram_bist #(.BURST_LEN(BL), .NUM_BURSTS(NB)) dut (
        .clk(clk), .rst_n(rst_n), .init_fin(init_fin), .start(start), .mode(mode),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_adr(first_err_adr), .cmd_en(cmd_en), .cmd_wr_rd(cmd_wr_rd),
        .cmd_av(cmd_av), .cmd_len(cmd_len), .cmd_adr(cmd_adr),
        .wr_remain_space(wr_remain_space), .wr_en(wr_en), .wr_data(wr_data),
        .rd_av(rd_av), .rd_en(rd_en), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pass;
        logic [15:0] err;
        logic [24:0] first;
    } res_t;

    logic [15:0] exp_wr[$];
    logic [25:0] exp_cmd[$];
    res_t        exp_res[$];

    int   total = 0;
    int   bad = 0;

    logic [15:0] mem [0:63];
    bit          corrupt [0:63];
    logic [15:0] wq[$];
    logic [15:0] rq[$];
    bit          rand_stall = 1'b0;
    bit          cmd_hold = 1'b0;
    bit          space_low = 1'b0;
    logic        cav_at_edge = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic record_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s unexpected event", name);
    endtask

    // Reference pattern computed directly from the pattern definitions
    function automatic logic [15:0] ref_word(input logic [1:0] m, input int k);
        logic [15:0] s;
        logic        fb;
        s = 16'hACE1;
        case (m)
            2'd0: return (k % 2 == 0) ? 16'hAAAA : 16'h5555;
            2'd1: return 16'(k);
            2'd2: return 16'h0001 << (k % 16);
            2'd3: begin
                for (int j = 0; j < k; j++) begin
                    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
                    s  = {fb, s[15:1]};
                end
                return s;
            end
            default: return 16'h0000;
        endcase
    endfunction

    // Ideal controller: write FIFO, memory, read FIFO with optional stalls
    initial begin
        logic        pop;
        logic [15:0] nd, d;
        int          a;
        forever begin
            @(posedge clk);
            cav_at_edge = cmd_av;
            pop = 1'b0;
            if (!rst_n) begin
                wq.delete();
                rq.delete();
            end else begin
                if (wr_en) wq.push_back(wr_data);
                if (cmd_en) begin
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        a = (int'(cmd_adr) + i) % 64;
                        if (!cmd_wr_rd) begin
                            if (wq.size() > 0) mem[a] = wq.pop_front();
                        end else begin
                            d = mem[a];
                            if (corrupt[a]) d = d ^ 16'h0001;
                            rq.push_back(d);
                        end
                    end
                end
                if (rd_en && rd_av) begin
                    pop = 1'b1;
                    nd  = (rq.size() > 0) ? rq.pop_front() : 16'hDEAD;
                end
            end
            #1;
            if (pop) rd_data = nd;
            rd_av  = (rq.size() > 0) && (!rand_stall || $urandom_range(0, 3) != 0);
            cmd_av = !cmd_hold && (!rand_stall || $urandom_range(0, 3) != 0);
            wr_remain_space = space_low ? 10'(BL - 1) : 10'(16 - wq.size());
        end
    end

    // Monitor: pops expectations whenever the DUT presents a write, command or completion
    initial begin
        logic done_q;
        res_t r;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wr_en) begin
                    if (exp_wr.size() == 0) record_fail("wr_extra");
                    else check("wr_data", wr_data, exp_wr.pop_front());
                end
                if (cmd_en) begin
                    check("cmd_av_at_strobe", cav_at_edge, 1);
                    check("cmd_len", cmd_len, BL);
                    if (exp_cmd.size() == 0) record_fail("cmd_extra");
                    else check("cmd_rw_adr", {cmd_wr_rd, cmd_adr}, exp_cmd.pop_front());
                end
                if (done && !done_q) begin
                    if (exp_res.size() == 0) record_fail("done_extra");
                    else begin
                        r = exp_res.pop_front();
                        check("pass", pass, r.pass);
                        check("err_cnt", err_cnt, r.err);
                        check("first_err_adr", first_err_adr, r.first);
                        check("busy_at_done", busy, 0);
                    end
                end
            end
            done_q = done;
        end
    end

    task automatic launch(input logic [1:0] m, input logic [5:0] cmask);
        res_t        r;
        int          nerr;
        logic [24:0] first;
        bit          found;
        nerr  = 0;
        first = 25'd0;
        found = 1'b0;
        for (int k = 0; k < 64; k++) corrupt[k] = 1'b0;
        for (int k = 0; k < NW; k++) begin
            exp_wr.push_back(ref_word(m, k));
            corrupt[k] = cmask[k];
            if (cmask[k]) begin
                nerr++;
                if (!found) begin
                    first = 25'(k);
                    found = 1'b1;
                end
            end
        end
        for (int b = 0; b < NB; b++) exp_cmd.push_back({1'b0, 25'(b * BL)});
        for (int b = 0; b < NB; b++) exp_cmd.push_back({1'b1, 25'(b * BL)});
        r.pass  = (nerr == 0);
        r.err   = 16'(nerr);
        r.first = first;
        exp_res.push_back(r);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_timeout done=%b required=1", tag, done);
        end
        @(negedge clk);
        check({tag, "_wr_left"}, exp_wr.size(), 0);
        check({tag, "_cmd_left"}, exp_cmd.size(), 0);
        check({tag, "_res_left"}, exp_res.size(), 0);
    endtask

    function automatic logic [127:0] all_outs();
        return {busy, done, pass, err_cnt, first_err_adr, cmd_en, cmd_wr_rd, cmd_len,
                cmd_adr, wr_en, wr_data, rd_en};
    endfunction

    initial begin
        int n_wr, n_cmd;
        res_t r;
        for (int k = 0; k < 64; k++) begin
            mem[k]     = 16'h0000;
            corrupt[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        rst_n    = 1'b1;
        init_fin = 1'b1;
        repeat (2) @(negedge clk);

        // ALT, ideal controller
        launch(2'd0, 6'b000000);
        wait_done("alt");

        // ADDR with word 5 corrupted on readback
        launch(2'd1, 6'b100000);
        wait_done("addr_err");

        // Write FIFO short of space for 50 cycles
        space_low = 1'b1;
        @(negedge clk);
        launch(2'd2, 6'b000000);
        n_wr = 0;
        repeat (50) begin
            @(negedge clk);
            if (wr_en) n_wr++;
        end
        check("wr_en_while_no_space", n_wr, 0);
        space_low = 1'b0;
        wait_done("space");

        // Command port stalled, second start while busy
        cmd_hold = 1'b1;
        @(negedge clk);
        launch(2'd3, 6'b000000);
        n_cmd = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_en) n_cmd++;
            if (n_cmd == 0 && !start) start = 1'b1;
            else start = 1'b0;
        end
        start = 1'b0;
        check("cmd_en_while_stalled", n_cmd, 0);
        cmd_hold = 1'b0;
        wait_done("cmd_stall");

        // Initialisation lost mid-test
        cmd_hold = 1'b1;
        @(negedge clk);
        launch(2'd2, 6'b000000);
        repeat (15) @(negedge clk);
        exp_res.delete();
        r.pass  = 1'b0;
        r.err   = 16'h0000;
        r.first = 25'd0;
        exp_res.push_back(r);
        init_fin = 1'b0;
        repeat (3) @(negedge clk);
        exp_wr.delete();
        exp_cmd.delete();
        wait_done("abort");
        wq.delete();
        init_fin = 1'b1;
        cmd_hold = 1'b0;
        @(negedge clk);

        // Randomised modes, error masks and controller stalls
        rand_stall = 1'b1;
        for (int t = 0; t < 6; t++) begin
            launch(2'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0);
            wait_done("random");
        end
        rand_stall = 1'b0;

        // Reset while draining reads, then a fresh LFSR test
        launch(2'd0, 6'b000000);
        n_wr = 0;
        while (rd_en !== 1'b1 && n_wr < 2000) begin
            @(negedge clk);
            n_wr++;
        end
        check("reached_rd_drain", rd_en, 1);
        #2;
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("outputs_in_reset", all_outs(), 0);
        end
        exp_wr.delete();
        exp_cmd.delete();
        exp_res.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", {busy, done}, 0);
        check("lfsr_ref_seed", ref_word(2'd3, 0), 16'hACE1);
        launch(2'd3, 6'b000000);
        wait_done("lfsr_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
